// File: rtl/pu_msp430_ram_dp.sv
// Two-port MSP430 data RAM: port A read/write with byte enables, port B read-only.
// Includes same-address write forwarding, out-of-range flags and post-reset zeroing.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing word[clr_cnt] each cycle, ports ignored, busy high
// ST_READY | normal two-port operation until the next reset
module pu_msp430_ram_dp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_MSB   = 6,
  parameter int MEM_SIZE   = 256,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                    ram_clk,
  input  logic                    ram_rst,
  input  logic [ADDR_MSB:0]       ram_a_addr,
  input  logic                    ram_a_cen,
  input  logic [DATA_WIDTH/8-1:0] ram_a_wen,
  input  logic [DATA_WIDTH-1:0]   ram_a_din,
  output logic [DATA_WIDTH-1:0]   ram_a_dout,
  output logic                    ram_a_err,
  input  logic [ADDR_MSB:0]       ram_b_addr,
  input  logic                    ram_b_cen,
  output logic [DATA_WIDTH-1:0]   ram_b_dout,
  output logic                    ram_b_err,
  output logic                    ram_busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int WORDS = MEM_SIZE / BYTES;
  localparam int AW    = ADDR_MSB + 1;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AW:0] WORDS_W = WORDS[AW:0];

  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam state_t ST_RESET = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_nxt;

  logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

  logic [IDX_W-1:0]      a_idx, b_idx;
  logic                  a_in_range, b_in_range;
  logic                  a_acc, b_acc, a_hit;
  logic [DATA_WIDTH-1:0] a_old, a_merged, b_old, b_data;

  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  a_err_q, b_err_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == IDX_W'(WORDS - 1)) state_nxt = ST_READY;
        else                              clr_cnt_nxt = clr_cnt + 1'b1;
      end
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_RESET;
    endcase
  end

  assign ram_busy = (state == ST_CLEAR);

  // ------------------------------------------------------- access decode
  assign a_idx      = ram_a_addr[IDX_W-1:0];
  assign b_idx      = ram_b_addr[IDX_W-1:0];
  assign a_in_range = ({1'b0, ram_a_addr} < WORDS_W);
  assign b_in_range = ({1'b0, ram_b_addr} < WORDS_W);
  assign a_acc      = !ram_busy && !ram_a_cen;
  assign b_acc      = !ram_busy && !ram_b_cen;
  assign a_hit      = a_acc && a_in_range && (ram_a_addr == ram_b_addr);

  always_comb begin
    a_old = '0;
    if (a_in_range) a_old = mem[a_idx];
    a_merged = a_old;
    for (int i = 0; i < BYTES; i++) begin
      if (!ram_a_wen[i]) a_merged[8*i +: 8] = ram_a_din[8*i +: 8];
    end
  end

  // Port B sees the post-write word when port A writes the same address.
  always_comb begin
    b_old = '0;
    if (b_in_range) b_old = mem[b_idx];
    b_data = a_hit ? a_merged : b_old;
  end

  // --------------------------------------------------------------- array
  always_ff @(posedge ram_clk) begin
    if (ram_busy) begin
      mem[clr_cnt] <= '0;
    end else if (a_acc && a_in_range) begin
      for (int i = 0; i < BYTES; i++) begin
        if (!ram_a_wen[i]) mem[a_idx][8*i +: 8] <= ram_a_din[8*i +: 8];
      end
    end
  end

  // ------------------------------------------------------ output stage 1
  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      a_q     <= '0;
      a_err_q <= 1'b0;
      b_q     <= '0;
      b_err_q <= 1'b0;
    end else if (ram_busy) begin
      a_q     <= '0;
      a_err_q <= 1'b0;
      b_q     <= '0;
      b_err_q <= 1'b0;
    end else begin
      a_err_q <= 1'b0;
      if (a_acc) begin
        a_q     <= a_in_range ? a_merged : '0;
        a_err_q <= !a_in_range;
      end
      b_err_q <= 1'b0;
      if (b_acc) begin
        b_q     <= b_in_range ? b_data : '0;
        b_err_q <= !b_in_range;
      end
    end
  end

  // ----------------------------------------------- optional output stage 2
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] a_q2, b_q2;
      logic                  a_err_q2, b_err_q2;

      always_ff @(posedge ram_clk or posedge ram_rst) begin
        if (ram_rst) begin
          a_q2     <= '0;
          a_err_q2 <= 1'b0;
          b_q2     <= '0;
          b_err_q2 <= 1'b0;
        end else begin
          a_q2     <= a_q;
          a_err_q2 <= a_err_q;
          b_q2     <= b_q;
          b_err_q2 <= b_err_q;
        end
      end

      assign ram_a_dout = a_q2;
      assign ram_a_err  = a_err_q2;
      assign ram_b_dout = b_q2;
      assign ram_b_err  = b_err_q2;
    end else begin : g_no_out_reg
      assign ram_a_dout = a_q;
      assign ram_a_err  = a_err_q;
      assign ram_b_dout = b_q;
      assign ram_b_err  = b_err_q;
    end
  endgenerate

endmodule

// File: tb/tb_pu_msp430_ram_dp.sv
// Bench for pu_msp430_ram_dp: a 16-bit instance with an 8-bit address checked every cycle
// against a word-array model, plus a 32-bit OUT_REG instance checked with directed values.
module tb_pu_msp430_ram_dp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // model-checked instance: 16-bit words, 128 words, 8-bit address
  logic [7:0]  m_a_addr = '0;
  logic        m_a_cen  = 1'b1;
  logic [1:0]  m_a_wen  = 2'b11;
  logic [15:0] m_a_din  = '0;
  logic [15:0] m_a_dout;
  logic        m_a_err;
  logic [7:0]  m_b_addr = '0;
  logic        m_b_cen  = 1'b1;
  logic [15:0] m_b_dout;
  logic        m_b_err;
  logic        m_busy;

  // pipelined instance: 32-bit words, 128 words, OUT_REG=1
  logic [6:0]  p_a_addr = '0;
  logic        p_a_cen  = 1'b1;
  logic [3:0]  p_a_wen  = 4'hF;
  logic [31:0] p_a_din  = '0;
  logic [31:0] p_a_dout;
  logic        p_a_err;
  logic [6:0]  p_b_addr = '0;
  logic        p_b_cen  = 1'b1;
  logic [31:0] p_b_dout;
  logic        p_b_err;
  logic        p_busy;

  pu_msp430_ram_dp #(.DATA_WIDTH(16), .ADDR_MSB(7), .MEM_SIZE(256), .OUT_REG(0), .INIT_CLEAR(1)) dut_m (
    .ram_clk(clk), .ram_rst(rst),
    .ram_a_addr(m_a_addr), .ram_a_cen(m_a_cen), .ram_a_wen(m_a_wen), .ram_a_din(m_a_din),
    .ram_a_dout(m_a_dout), .ram_a_err(m_a_err),
    .ram_b_addr(m_b_addr), .ram_b_cen(m_b_cen), .ram_b_dout(m_b_dout), .ram_b_err(m_b_err),
    .ram_busy(m_busy)
  );

  pu_msp430_ram_dp #(.DATA_WIDTH(32), .ADDR_MSB(6), .MEM_SIZE(512), .OUT_REG(1), .INIT_CLEAR(1)) dut_p (
    .ram_clk(clk), .ram_rst(rst),
    .ram_a_addr(p_a_addr), .ram_a_cen(p_a_cen), .ram_a_wen(p_a_wen), .ram_a_din(p_a_din),
    .ram_a_dout(p_a_dout), .ram_a_err(p_a_err),
    .ram_b_addr(p_b_addr), .ram_b_cen(p_b_cen), .ram_b_dout(p_b_dout), .ram_b_err(p_b_err),
    .ram_busy(p_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  logic [15:0] mdl [0:127];
  int          clear_left = 128;
  logic [15:0] exp_a = '0, exp_b = '0;
  logic        exp_a_err = 1'b0, exp_b_err = 1'b0;

  always @(posedge clk) begin
    logic [15:0] w;
    if (rst) begin
      clear_left = 128;
      for (int i = 0; i < 128; i++) mdl[i] = '0;
      exp_a = '0; exp_b = '0; exp_a_err = 1'b0; exp_b_err = 1'b0;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_a = '0; exp_b = '0; exp_a_err = 1'b0; exp_b_err = 1'b0;
    end else begin
      exp_a_err = 1'b0;
      if (!m_a_cen) begin
        if (m_a_addr < 8'd128) begin
          w = mdl[m_a_addr[6:0]];
          if (!m_a_wen[0]) w[7:0]  = m_a_din[7:0];
          if (!m_a_wen[1]) w[15:8] = m_a_din[15:8];
          mdl[m_a_addr[6:0]] = w;
          exp_a = w;
        end else begin
          exp_a = '0;
          exp_a_err = 1'b1;
        end
      end
      exp_b_err = 1'b0;
      if (!m_b_cen) begin
        if (m_b_addr < 8'd128) exp_b = mdl[m_b_addr[6:0]];
        else begin
          exp_b = '0;
          exp_b_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_a_dout", {16'h0, m_a_dout}, {16'h0, exp_a});
      chk("m_a_err",  {31'h0, m_a_err},  {31'h0, exp_a_err});
      chk("m_b_dout", {16'h0, m_b_dout}, {16'h0, exp_b});
      chk("m_b_err",  {31'h0, m_b_err},  {31'h0, exp_b_err});
      chk("m_busy",   {31'h0, m_busy},   {31'h0, (clear_left > 0)});
    end
  end

  // --------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_op(input logic [7:0] addr, input logic [1:0] wen, input logic [15:0] din);
    m_a_addr = addr; m_a_cen = 1'b0; m_a_wen = wen; m_a_din = din;
    tick();
    m_a_cen = 1'b1; m_a_wen = 2'b11;
  endtask

  task automatic wait_clear(input string nm);
    int n = 0;
    while (m_busy && n < 300) begin
      tick();
      n++;
    end
    chk(nm, n, 128);
  endtask

  task automatic read_all_b_zero(input string nm);
    for (int a = 0; a < 128; a++) begin
      m_b_addr = 8'(a); m_b_cen = 1'b0;
      tick();
      chk(nm, {16'h0, m_b_dout}, 32'h0);
      chk({nm, "_err"}, {31'h0, m_b_err}, 32'h0);
    end
    m_b_cen = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("busy_after_rst", {31'h0, m_busy}, 32'h1);
    chk("p_busy_after_rst", {31'h0, p_busy}, 32'h1);
    wait_clear("busy_len");
    chk("p_busy_done", {31'h0, p_busy}, 32'h0);
    read_all_b_zero("clear_b");

    // byte lanes
    a_op(8'd5, 2'b00, 16'hA5C3); chk("bw_full",  {16'h0, m_a_dout}, 32'hA5C3);
    a_op(8'd5, 2'b01, 16'h11FF); chk("bw_hi",    {16'h0, m_a_dout}, 32'h11C3);
    a_op(8'd5, 2'b11, 16'h0000); chk("bw_rd",    {16'h0, m_a_dout}, 32'h11C3);
    a_op(8'd5, 2'b10, 16'h2222); chk("bw_lo",    {16'h0, m_a_dout}, 32'h1122);

    // same-cycle forwarding, full and partial
    m_b_addr = 8'd9; m_b_cen = 1'b0;
    a_op(8'd9, 2'b00, 16'hBEEF);
    chk("fwd_b", {16'h0, m_b_dout}, 32'hBEEF);
    chk("fwd_a", {16'h0, m_a_dout}, 32'hBEEF);
    m_b_addr = 8'd5;
    a_op(8'd5, 2'b01, 16'h3300);
    chk("fwd_part", {16'h0, m_b_dout}, 32'h3322);
    m_b_addr = 8'd9;
    a_op(8'd10, 2'b00, 16'h0A0A);
    chk("b_other", {16'h0, m_b_dout}, 32'hBEEF);
    m_b_cen = 1'b1;
    tick();
    chk("hold_a", {16'h0, m_a_dout}, 32'h0A0A);
    chk("hold_b", {16'h0, m_b_dout}, 32'hBEEF);

    // out-of-range and boundaries
    a_op(8'd200, 2'b00, 16'h1234);
    chk("oor_err", {31'h0, m_a_err}, 32'h1);
    chk("oor_dout", {16'h0, m_a_dout}, 32'h0);
    tick();
    chk("oor_err_clr", {31'h0, m_a_err}, 32'h0);
    a_op(8'd72, 2'b11, 16'h0); chk("alias72", {16'h0, m_a_dout}, 32'h0);
    a_op(8'd0,  2'b11, 16'h0); chk("addr0",   {16'h0, m_a_dout}, 32'h0);
    a_op(8'd127, 2'b00, 16'h7F7F); chk("top_word", {16'h0, m_a_dout}, 32'h7F7F);
    a_op(8'd128, 2'b00, 16'h5555); chk("first_oor", {31'h0, m_a_err}, 32'h1);
    m_b_addr = 8'd255; m_b_cen = 1'b0;
    tick();
    chk("b_oor_err", {31'h0, m_b_err}, 32'h1);
    chk("b_oor_dout", {16'h0, m_b_dout}, 32'h0);
    m_b_addr = 8'd127;
    tick();
    chk("b_top", {16'h0, m_b_dout}, 32'h7F7F);
    m_b_cen = 1'b1;

    // mixed back-to-back traffic, checked by the model
    for (int i = 0; i < 80; i++) begin
      m_a_addr = 8'($urandom_range(0, 140));
      m_a_cen  = ($urandom_range(0, 3) == 0);
      m_a_wen  = 2'($urandom_range(0, 3));
      m_a_din  = 16'($urandom);
      m_b_addr = ($urandom_range(0, 2) == 0) ? m_a_addr : 8'($urandom_range(0, 140));
      m_b_cen  = ($urandom_range(0, 3) == 0);
      tick();
    end
    m_a_cen = 1'b1; m_b_cen = 1'b1; m_a_wen = 2'b11;
    tick();

    // OUT_REG instance: two-cycle latency and hold
    p_a_addr = 7'd3; p_a_cen = 1'b0; p_a_wen = 4'h0; p_a_din = 32'hDEADBEEF;
    tick();
    p_a_addr = 7'd4; p_a_din = 32'h01020304;
    tick();
    p_a_addr = 7'd3; p_a_wen = 4'hF;
    p_b_addr = 7'd3; p_b_cen = 1'b0;
    tick();
    chk("p_lat1", p_a_dout, 32'h01020304);
    p_a_cen = 1'b1; p_b_cen = 1'b1;
    tick();
    chk("p_lat2", p_a_dout, 32'hDEADBEEF);
    chk("p_b_lat2", p_b_dout, 32'hDEADBEEF);
    tick();
    chk("p_hold", p_a_dout, 32'hDEADBEEF);
    chk("p_err", {31'h0, p_a_err}, 32'h0);
    p_a_addr = 7'd3; p_a_cen = 1'b0; p_a_wen = 4'b1010; p_a_din = 32'hAABBCCDD;
    tick();
    p_a_cen = 1'b1; p_a_wen = 4'hF;
    tick();
    chk("p_bytes", p_a_dout, 32'hDEBBBEDD);
    p_b_addr = 7'd3; p_b_cen = 1'b0;
    tick();
    p_b_cen = 1'b1;
    tick();
    chk("p_b_bytes", p_b_dout, 32'hDEBBBEDD);

    // reset mid-clear with writes attempted while busy
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      m_a_addr = 8'(i); m_a_cen = 1'b0; m_a_wen = 2'b00; m_a_din = 16'hFFFF;
      m_b_addr = 8'(i); m_b_cen = 1'b0;
      tick();
    end
    chk("busy_mid", {31'h0, m_busy}, 32'h1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    begin
      int n = 0;
      while (m_busy && n < 300) begin
        m_a_addr = 8'(n % 128); m_a_cen = 1'b0; m_a_wen = 2'b00; m_a_din = 16'hFFFF;
        tick();
        n++;
      end
      chk("busy_len_restart", n, 128);
    end
    m_a_cen = 1'b1; m_a_wen = 2'b11; m_b_cen = 1'b1;
    read_all_b_zero("restart_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
